// File: rtl/range_finder_wdt_kick_monitor_if.sv
// Signal bundle between the watchdog PIO/control side and the kick monitor.
// The master drives the kick/enable/ack inputs; the monitor (slave) returns its status.
interface range_finder_wdt_kick_monitor_if #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned FAULT_CNT_W = 8
);
  logic                   kick_in;
  logic                   enable;
  logic                   warn_ack;
  logic                   wd_reset_req;
  logic                   warn_irq;
  logic                   armed;
  logic [1:0]             bite_cause;
  logic [FAULT_CNT_W-1:0] fault_count;
  logic [CNT_W-1:0]       count_out;

  modport master (
    output kick_in, enable, warn_ack,
    input  wd_reset_req, warn_irq, armed, bite_cause, fault_count, count_out
  );

  modport slave (
    input  kick_in, enable, warn_ack,
    output wd_reset_req, warn_irq, armed, bite_cause, fault_count, count_out
  );
endinterface

// File: rtl/range_finder_wdt_kick_monitor.sv
// Windowed watchdog for the Range_finder PIO kick bit: times kick intervals,
// raises an early warning, and issues a fixed-width reset request on timeout or early kick.
//
// state | meaning
// IDLE  | watchdog disabled, counter held at 0, kicks ignored
// ARMED | timing the interval since the last kick (or since arming)
// BITE  | driving wd_reset_req for RST_PULSE_CYCLES cycles
module range_finder_wdt_kick_monitor #(
  parameter int unsigned CNT_W             = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 50000000,
  parameter int unsigned WARN_CYCLES       = 5000000,
  parameter int unsigned WINDOW_MIN_CYCLES = 0,
  parameter int unsigned RST_PULSE_CYCLES  = 16,
  parameter int unsigned FAULT_CNT_W       = 8
) (
  input logic                           clk,
  input logic                           reset_n,
  range_finder_wdt_kick_monitor_if.slave bus
);

  localparam int unsigned PULSE_W = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_TERM   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_WARN   = CNT_W'(TIMEOUT_CYCLES - WARN_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_WIN    = CNT_W'(WINDOW_MIN_CYCLES);
  localparam bit                 WARN_EN    = (WARN_CYCLES > 0);
  localparam bit                 WIN_EN     = (WINDOW_MIN_CYCLES > 0);

  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_EARLY   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    BITE  = 2'b10
  } state_t;

  state_t                 state_q, state_nxt;
  logic                   kick_q;
  logic                   kick_evt;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt, cnt_inc;
  logic                   first_q, first_nxt;
  logic                   warn_q, warn_nxt;
  logic                   req_q, req_nxt;
  logic                   armed_q;
  logic [1:0]             cause_q, cause_nxt;
  logic [FAULT_CNT_W-1:0] fault_q, fault_nxt;
  logic [PULSE_W-1:0]     pulse_q, pulse_nxt;

  // The PIO resets to 0 like kick_q, so no phantom edge appears at reset release.
  assign kick_evt = bus.kick_in ^ kick_q;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      kick_q  <= 1'b0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      warn_q  <= 1'b0;
      req_q   <= 1'b0;
      armed_q <= 1'b0;
      cause_q <= 2'b00;
      fault_q <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_nxt;
      kick_q  <= bus.kick_in;
      cnt_q   <= cnt_nxt;
      first_q <= first_nxt;
      warn_q  <= warn_nxt;
      req_q   <= req_nxt;
      armed_q <= (state_nxt == ARMED);
      cause_q <= cause_nxt;
      fault_q <= fault_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    first_nxt = first_q;
    warn_nxt  = warn_q;
    req_nxt   = req_q;
    cause_nxt = cause_q;
    fault_nxt = fault_q;
    pulse_nxt = pulse_q;

    unique case (state_q)
      IDLE: begin
        cnt_nxt  = '0;
        warn_nxt = 1'b0;
        if (bus.enable) begin
          state_nxt = ARMED;
          first_nxt = 1'b1;
        end
      end

      ARMED: begin
        if (bus.warn_ack) begin
          warn_nxt = 1'b0;
        end
        if (!bus.enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          warn_nxt  = 1'b0;
        end else if (kick_evt && !first_q && WIN_EN && (cnt_q < CNT_WIN)) begin
          state_nxt = BITE;
          cause_nxt = CAUSE_EARLY;
        end else if (kick_evt) begin
          cnt_nxt   = '0;
          first_nxt = 1'b0;
          warn_nxt  = 1'b0;
        end else if (cnt_q == CNT_TERM) begin
          state_nxt = BITE;
          cause_nxt = CAUSE_TIMEOUT;
        end else begin
          cnt_nxt = cnt_inc;
          // Setting takes priority over a same-cycle warn_ack.
          if (WARN_EN && (cnt_inc == CNT_WARN)) begin
            warn_nxt = 1'b1;
          end
        end

        if (state_nxt == BITE) begin
          cnt_nxt   = '0;
          warn_nxt  = 1'b0;
          req_nxt   = 1'b1;
          pulse_nxt = PULSE_LAST;
          if (fault_q != '1) begin
            fault_nxt = fault_q + FAULT_CNT_W'(1);
          end
        end
      end

      BITE: begin
        if (pulse_q == '0) begin
          req_nxt = 1'b0;
          if (bus.enable) begin
            state_nxt = ARMED;
            first_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          pulse_nxt = pulse_q - PULSE_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        warn_nxt  = 1'b0;
        req_nxt   = 1'b0;
      end
    endcase
  end

  assign bus.wd_reset_req = req_q;
  assign bus.warn_irq     = warn_q;
  assign bus.armed        = armed_q;
  assign bus.bite_cause   = cause_q;
  assign bus.fault_count  = fault_q;
  assign bus.count_out    = cnt_q;

endmodule

// File: tb/tb_range_finder_wdt_kick_monitor.sv
// Directed scoreboard bench for the kick monitor: expectations are queued as stimulus
// is applied and popped against the DUT outputs sampled on the falling clock edge.
module tb_range_finder_wdt_kick_monitor;

  localparam int unsigned CNT_W       = 32;
  localparam int unsigned FAULT_CNT_W = 8;

  logic clk;
  logic reset_n;

  range_finder_wdt_kick_monitor_if #(.CNT_W(CNT_W), .FAULT_CNT_W(FAULT_CNT_W)) bus ();

  range_finder_wdt_kick_monitor #(
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(100),
    .WARN_CYCLES(20),
    .WINDOW_MIN_CYCLES(10),
    .RST_PULSE_CYCLES(4),
    .FAULT_CNT_W(FAULT_CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.enable   = 1'b0;
    bus.kick_in  = 1'b0;
    bus.warn_ack = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic arm();
    bus.enable = 1'b1;
    step(1);
  endtask

  task automatic toggle_kick();
    bus.kick_in = ~bus.kick_in;
  endtask

  initial begin
    #1000000;
    $display("FAIL tb_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

  int  max_cnt;
  bit  warn_seen;
  bit  req_seen;

  initial begin
    reset_n      = 1'b0;
    bus.enable   = 1'b0;
    bus.kick_in  = 1'b0;
    bus.warn_ack = 1'b0;

    // Reset state
    step(2);
    expect_val("rst_req", 0);    check(bus.wd_reset_req);
    expect_val("rst_warn", 0);   check(bus.warn_irq);
    expect_val("rst_armed", 0);  check(bus.armed);
    expect_val("rst_cause", 0);  check(bus.bite_cause);
    expect_val("rst_fault", 0);  check(bus.fault_count);
    expect_val("rst_count", 0);  check(bus.count_out);
    reset_n = 1'b1;
    step(1);

    // 1: timeout with no kicks
    expect_val("t1_armed", 1);
    expect_val("t1_count0", 0);
    arm();
    check(bus.armed);
    check(bus.count_out);
    expect_val("t1_count79", 79);
    expect_val("t1_warn_pre", 0);
    step(79);
    check(bus.count_out);
    check(bus.warn_irq);
    expect_val("t1_count80", 80);
    expect_val("t1_warn_set", 1);
    step(1);
    check(bus.count_out);
    check(bus.warn_irq);
    expect_val("t1_count99", 99);
    expect_val("t1_req_pre", 0);
    step(19);
    check(bus.count_out);
    check(bus.wd_reset_req);
    expect_val("t1_req_rise", 1);
    expect_val("t1_cause", 1);
    expect_val("t1_fault", 1);
    expect_val("t1_armed_bite", 0);
    expect_val("t1_warn_bite", 0);
    step(1);
    check(bus.wd_reset_req);
    check(bus.bite_cause);
    check(bus.fault_count);
    check(bus.armed);
    check(bus.warn_irq);
    expect_val("t1_req_last", 1);
    step(3);
    check(bus.wd_reset_req);
    expect_val("t1_req_fall", 0);
    expect_val("t1_rearmed", 1);
    expect_val("t1_rearm_count", 0);
    step(1);
    check(bus.wd_reset_req);
    check(bus.armed);
    check(bus.count_out);

    // 2: regular kicks every 50 cycles
    do_reset();
    arm();
    max_cnt   = 0;
    warn_seen = 1'b0;
    req_seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      toggle_kick();
      for (int j = 0; j < 50; j++) begin
        step(1);
        if (int'(bus.count_out) > max_cnt) max_cnt = int'(bus.count_out);
        if (bus.warn_irq) warn_seen = 1'b1;
        if (bus.wd_reset_req) req_seen = 1'b1;
      end
    end
    expect_val("t2_max_count_le51", 1);  check(32'(max_cnt <= 51));
    expect_val("t2_warn_never", 0);      check(32'(warn_seen));
    expect_val("t2_req_never", 0);       check(32'(req_seen));
    expect_val("t2_fault", 0);           check(bus.fault_count);
    expect_val("t2_armed", 1);           check(bus.armed);

    // 3: first kick exempt from window, third kick too early
    do_reset();
    arm();
    step(2);
    expect_val("t3_count2", 2);
    check(bus.count_out);
    toggle_kick();
    expect_val("t3_k1_count", 0);
    expect_val("t3_k1_fault", 0);
    expect_val("t3_k1_armed", 1);
    step(1);
    check(bus.count_out);
    check(bus.fault_count);
    check(bus.armed);
    step(30);
    expect_val("t3_count30", 30);
    check(bus.count_out);
    toggle_kick();
    expect_val("t3_k2_count", 0);
    expect_val("t3_k2_fault", 0);
    step(1);
    check(bus.count_out);
    check(bus.fault_count);
    step(5);
    toggle_kick();
    expect_val("t3_k3_req", 1);
    expect_val("t3_k3_cause", 2);
    expect_val("t3_k3_fault", 1);
    step(1);
    check(bus.wd_reset_req);
    check(bus.bite_cause);
    check(bus.fault_count);

    // 4: kick on the last legal cycle, then warn_ack
    do_reset();
    arm();
    step(99);
    expect_val("t4_count99", 99);
    expect_val("t4_warn_before_kick", 1);
    check(bus.count_out);
    check(bus.warn_irq);
    toggle_kick();
    expect_val("t4_kick_count", 0);
    expect_val("t4_kick_req", 0);
    expect_val("t4_kick_warn", 0);
    expect_val("t4_kick_fault", 0);
    step(1);
    check(bus.count_out);
    check(bus.wd_reset_req);
    check(bus.warn_irq);
    check(bus.fault_count);
    step(85);
    expect_val("t4_count85", 85);
    expect_val("t4_warn85", 1);
    check(bus.count_out);
    check(bus.warn_irq);
    bus.warn_ack = 1'b1;
    expect_val("t4_ack_warn", 0);
    step(1);
    bus.warn_ack = 1'b0;
    check(bus.warn_irq);
    warn_seen = 1'b0;
    for (int j = 0; j < 13; j++) begin
      step(1);
      if (bus.warn_irq) warn_seen = 1'b1;
    end
    expect_val("t4_count99_again", 99);
    expect_val("t4_warn_stays_low", 0);
    check(bus.count_out);
    check(32'(warn_seen));
    expect_val("t4_timeout_req", 1);
    expect_val("t4_timeout_cause", 1);
    step(1);
    check(bus.wd_reset_req);
    check(bus.bite_cause);

    // 5: disable mid-interval, kicks while idle, re-enable
    do_reset();
    arm();
    step(60);
    bus.enable = 1'b0;
    expect_val("t5_idle_armed", 0);
    expect_val("t5_idle_count", 0);
    expect_val("t5_idle_req", 0);
    step(1);
    check(bus.armed);
    check(bus.count_out);
    check(bus.wd_reset_req);
    toggle_kick(); step(3);
    toggle_kick(); step(3);
    toggle_kick(); step(2);
    expect_val("t5_idle_count_kicks", 0);
    check(bus.count_out);
    expect_val("t5_rearm_armed", 1);
    expect_val("t5_rearm_count", 0);
    arm();
    check(bus.armed);
    check(bus.count_out);
    step(99);
    expect_val("t5_no_early_fault", 0);
    expect_val("t5_count99", 99);
    check(bus.fault_count);
    check(bus.count_out);
    expect_val("t5_timeout_req", 1);
    expect_val("t5_timeout_cause", 1);
    step(1);
    check(bus.wd_reset_req);
    check(bus.bite_cause);

    // 6a: async reset during the second pulse cycle
    do_reset();
    arm();
    step(100);
    expect_val("t6_req_first", 1);
    check(bus.wd_reset_req);
    step(1);
    expect_val("t6_req_second", 1);
    check(bus.wd_reset_req);
    reset_n = 1'b0;
    #1;
    expect_val("t6_rst_req", 0);
    expect_val("t6_rst_fault", 0);
    expect_val("t6_rst_cause", 0);
    expect_val("t6_rst_armed", 0);
    check(bus.wd_reset_req);
    check(bus.fault_count);
    check(bus.bite_cause);
    check(bus.armed);

    // 6b: fault counter saturation via repeated early kicks
    do_reset();
    arm();
    for (int i = 0; i < 300; i++) begin
      toggle_kick();
      step(1);
      toggle_kick();
      step(1);
      if (i == 253) begin
        expect_val("t6_fault_254", 254);
        check(bus.fault_count);
      end
      step(4);
    end
    expect_val("t6_fault_sat", 255);
    expect_val("t6_cause_early", 2);
    expect_val("t6_rearmed", 1);
    check(bus.fault_count);
    check(bus.bite_cause);
    check(bus.armed);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
